exe_mdu: RTL and testbench

EXE_MDU -- requirements
Module: exe_mdu

---
 rtl/mdu_pkg.sv | 40 ++++
 rtl/mdu_div_iter.sv | 63 ++++++
 rtl/exe_mdu.sv | 247 ++++++++++++++++++++++++
 tb/tb_exe_mdu.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// mdu_pkg -- shared definitions for the EX-stage multiply/divide unit.
//
// Contents:
//   OP_*           op_code encodings accepted by exe_mdu
//   mdu_state_e    FSM state encoding (IDLE / RUN / DONE)
//   DIV0_QUOTIENT  quotient written to LO on divide by zero; sliced to XLEN
//                  by the user. HI on divide by zero is the raw dividend.
//   op_is_mul / op_is_div / op_is_signed  op_code classification helpers
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_NOP   = 3'd6;  // 3'd7 also behaves as NOP

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  // Divide-by-zero quotient: all ones at any XLEN up to 64.
  localparam logic [63:0] DIV0_QUOTIENT = '1;

  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// mdu_div_iter -- unsigned restoring divide core, one quotient bit per step.
//
// Parameters:
//   XLEN       operand width
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   start      load dividend/divisor and clear the partial remainder
//   step       perform one restoring iteration at this edge
//   dividend   unsigned dividend (sampled on start)
//   divisor    unsigned divisor  (sampled on start)
//   quotient   quotient register value after the current step
//   remainder  remainder register value after the current step
//
// The outputs are the values the registers take at the coming edge when
// step is high. On the XLEN-th step they are the final quotient and
// remainder, so the owner can commit them at that same edge without waiting
// an extra cycle. Sign handling and divide-by-zero results live in the owner;
// with a zero divisor this core produces an all-ones quotient and a
// meaningless remainder.
module mdu_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] quo;  // dividend bits shift out the top, quotient bits in
  logic [XLEN-1:0] rem;  // partial remainder
  logic [XLEN-1:0] dsr;  // latched divisor
  logic [XLEN:0]   shifted;
  logic            ge;

  // Bring the next dividend bit into the partial remainder; subtract the
  // divisor when it fits. When it fits the difference is below the divisor,
  // so modular XLEN-bit subtraction gives the exact result.
  assign shifted   = {rem, quo[XLEN-1]};
  assign ge        = (shifted >= {1'b0, dsr});
  assign quotient  = {quo[XLEN-2:0], ge};
  assign remainder = ge ? (shifted[XLEN-1:0] - dsr) : shifted[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
    end else if (start) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
    end else if (step) begin
      quo <= quotient;
      rem <= remainder;
    end
  end

endmodule

// File: rtl/exe_mdu.sv
// exe_mdu -- EX-stage multiply/divide unit owning the architectural HI/LO.
//
// Parameters:
//   XLEN       operand/HI/LO width (even, 8..64)
//   CNT_W      iteration counter width (holds XLEN)
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   op_valid   operation request
//   op_ready   request can be accepted this cycle
//   op_code    0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 NOP
//   op_src1    rs / dividend / multiplicand
//   op_src2    rt / divisor / multiplier
//   flush      exception/ERET cancel from MEM/WB
//   res_valid  one-cycle pulse: HI/LO now hold the completed result
//   busy       a multi-cycle operation is in flight (RUN or DONE)
//   hi, lo     architectural HI/LO registers
//   dbg_state  current FSM state, for observation only
//
// Configuration macro: EXE_MDU_FAST_MUL_EN
//   defined   -> MULT/MULTU complete in one cycle from a combinational product
//   undefined -> MULT/MULTU run the iterative shift-add path, same latency as
//                divide (XLEN+1 cycles from acceptance to res_valid)
//
// Handshake: a request is taken at a rising edge where op_valid && op_ready
// && !flush. op_ready is high only in IDLE and outside reset; op_valid may be
// held across busy cycles and is simply not taken until the unit is IDLE.
// Operands are captured at the accepting edge and never read again.
//
// Iterative timing: accepting edge loads the operands (cycle 0); RUN does one
// step per edge for XLEN edges; the last step commits HI/LO and moves to
// DONE, where res_valid is high; DONE always returns to IDLE.
module exe_mdu
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            op_valid,
  output logic            op_ready,
  input  logic [2:0]      op_code,
  input  logic [XLEN-1:0] op_src1,
  input  logic [XLEN-1:0] op_src2,
  input  logic            flush,
  output logic            res_valid,
  output logic            busy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output mdu_state_e      dbg_state
);

`ifdef EXE_MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  mdu_state_e        state;
  logic [CNT_W-1:0]  cnt;

  // Operation context captured at acceptance.
  logic              run_mul;       // iterating a multiply (else a divide)
  logic              neg_main;      // negate quotient / product
  logic              neg_rem;       // negate remainder (sign of dividend)
  logic              div_zero;      // divisor was zero
  logic [XLEN-1:0]   dividend_raw;  // unmodified src1 for the div-by-zero HI

  // Shift-add multiplier state: mul_hi accumulates, mul_lo holds the
  // remaining multiplier bits and collects product bits from the top.
  logic [XLEN-1:0]   mcand;
  logic [XLEN-1:0]   mul_hi;
  logic [XLEN-1:0]   mul_lo;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi_nxt;
  logic [XLEN-1:0]   mul_lo_nxt;

  logic              accept;
  logic              go_iter;
  logic              last_step;
  logic              src1_neg;
  logic              src2_neg;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;

  logic              div_start;
  logic              div_step;
  logic [XLEN-1:0]   quo_nxt;
  logic [XLEN-1:0]   rem_nxt;

  logic [2*XLEN-1:0] prod_mag;
  logic [2*XLEN-1:0] prod_fin;
  logic [XLEN-1:0]   quo_fin;
  logic [XLEN-1:0]   rem_fin;

  assign op_ready  = (state == ST_IDLE) && !reset;
  assign busy      = (state == ST_RUN) || (state == ST_DONE);
  assign dbg_state = state;

  assign accept  = op_valid && op_ready && !flush;
  assign go_iter = accept &&
                   (op_is_div(op_code) || (op_is_mul(op_code) && !FAST_MUL));

  // The XLEN-th RUN edge: counter goes from XLEN-1 to XLEN.
  assign last_step = (state == ST_RUN) && (cnt == CNT_W'(XLEN - 1));

  // Signed operations work on magnitudes. The most-negative value maps to
  // itself, which read as unsigned is its correct magnitude; this is also
  // why most-negative / -1 yields LO = most-negative, HI = 0 with no
  // special case.
  assign src1_neg = op_is_signed(op_code) && op_src1[XLEN-1];
  assign src2_neg = op_is_signed(op_code) && op_src2[XLEN-1];
  assign mag1     = src1_neg ? -op_src1 : op_src1;
  assign mag2     = src2_neg ? -op_src2 : op_src2;

  assign div_start = go_iter && op_is_div(op_code);
  assign div_step  = (state == ST_RUN) && !run_mul;

  mdu_div_iter #(
    .XLEN (XLEN)
  ) u_div_iter (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .step      (div_step),
    .dividend  (mag1),
    .divisor   (mag2),
    .quotient  (quo_nxt),
    .remainder (rem_nxt)
  );

  // One shift-add step: conditionally add the multiplicand to the upper
  // half, then shift the whole 2*XLEN+1 value right by one.
  assign mul_sum    = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, mcand} : '0);
  assign mul_hi_nxt = mul_sum[XLEN:1];
  assign mul_lo_nxt = {mul_sum[0], mul_lo[XLEN-1:1]};

  // Final results, valid on the last step.
  assign prod_mag = {mul_hi_nxt, mul_lo_nxt};
  assign prod_fin = neg_main ? -prod_mag : prod_mag;
  assign quo_fin  = div_zero ? DIV0_QUOTIENT[XLEN-1:0]
                             : (neg_main ? -quo_nxt : quo_nxt);
  assign rem_fin  = div_zero ? dividend_raw
                             : (neg_rem ? -rem_nxt : rem_nxt);

`ifdef EXE_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_ext1;
  logic [2*XLEN-1:0] fast_ext2;
  logic [2*XLEN-1:0] fast_prod;

  // Sign- or zero-extend to 2*XLEN; the low 2*XLEN bits of the product are
  // the exact signed or unsigned result.
  assign fast_ext1 = {{XLEN{src1_neg}}, op_src1};
  assign fast_ext2 = {{XLEN{src2_neg}}, op_src2};
  assign fast_prod = fast_ext1 * fast_ext2;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      hi           <= '0;
      lo           <= '0;
      res_valid    <= 1'b0;
      run_mul      <= 1'b0;
      neg_main     <= 1'b0;
      neg_rem      <= 1'b0;
      div_zero     <= 1'b0;
      dividend_raw <= '0;
      mcand        <= '0;
      mul_hi       <= '0;
      mul_lo       <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (go_iter) begin
              state        <= ST_RUN;
              run_mul      <= op_is_mul(op_code);
              neg_main     <= src1_neg ^ src2_neg;
              neg_rem      <= src1_neg;
              div_zero     <= (op_src2 == '0);
              dividend_raw <= op_src1;
              mcand        <= mag1;
              mul_hi       <= '0;
              mul_lo       <= mag2;
            end else begin
              // Single-cycle ops commit at the accepting edge.
              case (op_code)
                OP_MTHI: hi <= op_src1;
                OP_MTLO: lo <= op_src1;
`ifdef EXE_MDU_FAST_MUL_EN
                OP_MULT, OP_MULTU: begin
                  hi <= fast_prod[2*XLEN-1:XLEN];
                  lo <= fast_prod[XLEN-1:0];
                end
`endif
                default: ;
              endcase
              res_valid <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (flush) begin
            // Cancelled before the committing edge: HI/LO untouched.
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (run_mul) begin
              mul_hi <= mul_hi_nxt;
              mul_lo <= mul_lo_nxt;
            end
            if (last_step) begin
              state     <= ST_DONE;
              res_valid <= 1'b1;
              if (run_mul) begin
                hi <= prod_fin[2*XLEN-1:XLEN];
                lo <= prod_fin[XLEN-1:0];
              end else begin
                hi <= rem_fin;
                lo <= quo_fin;
              end
            end
          end
        end

        ST_DONE: begin
          // HI/LO already committed; a flush here changes nothing.
          state <= ST_IDLE;
          cnt   <= '0;
        end

        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exe_mdu.sv
// tb_exe_mdu -- directed and lightly randomised bench for exe_mdu (XLEN=32).
// Expected HI/LO pairs are pushed to exp_q when an operation is driven and
// popped by a monitor whenever res_valid is seen.
module tb_exe_mdu;
  import mdu_pkg::*;

  localparam int XLEN = 32;
  localparam int DIV_LAT = XLEN + 1;
`ifdef EXE_MDU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif

  logic            clk;
  logic            reset;
  logic            op_valid;
  logic            op_ready;
  logic [2:0]      op_code;
  logic [XLEN-1:0] op_src1;
  logic [XLEN-1:0] op_src2;
  logic            flush;
  logic            res_valid;
  logic            busy;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  mdu_state_e      dbg_state;

  exe_mdu #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_code   (op_code),
    .op_src1   (op_src1),
    .op_src2   (op_src2),
    .flush     (flush),
    .res_valid (res_valid),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model built from native SV arithmetic; returns {hi, lo}.
  function automatic logic [63:0] ref_result(input logic [2:0] code, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] h0,
                                             input logic [31:0] l0);
    logic signed [63:0] sa, sb, sp;
    logic signed [31:0] qa, qb, qq, qr;
    logic [63:0] up;
    case (code)
      OP_MULT: begin
        sa = $signed(a);
        sb = $signed(b);
        sp = sa * sb;
        return sp;
      end
      OP_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      OP_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        qa = a;
        qb = b;
        qq = qa / qb;
        qr = qa % qb;
        return {qr, qq};
      end
      OP_DIVU: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      OP_MTHI: return {a, l0};
      OP_MTLO: return {h0, a};
      default: return {h0, l0};
    endcase
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [63:0] e;
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        check("res_valid_unexpected", 64'(res_valid), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("result_hilo", {hi, lo}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op_code  = code;
    op_src1  = a;
    op_src2  = b;
  endtask

  task automatic push_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    e = ref_result(code, a, b, cur_hi, cur_lo);
    exp_q.push_back(e);
    cur_hi = e[63:32];
    cur_lo = e[31:0];
  endtask

  task automatic run_op(input string tag, input logic [2:0] code, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat);
    int lat;
    for (int i = 0; i < 50 && !op_ready; i++) tick();
    drive(code, a, b);
    push_op(code, a, b);
    tick();
    op_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 100) begin
      op_src1 = $urandom;  // operands must not matter after acceptance
      op_src2 = $urandom;
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  function automatic int lat_of(input logic [2:0] code);
    if (op_is_mul(code)) return MUL_LAT;
    if (op_is_div(code)) return DIV_LAT;
    return 1;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    logic [2:0]  rc;
    logic [31:0] ra, rb;

    reset    = 1'b1;
    op_valid = 1'b1;     // reset must override a request and a flush
    op_code  = OP_MTHI;
    op_src1  = 32'hDEAD_BEEF;
    op_src2  = 32'd0;
    flush    = 1'b1;
    repeat (3) tick();
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_res_valid", 64'(res_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_op_ready", 64'(op_ready), 64'd0);
    op_valid = 1'b0;
    flush    = 1'b0;
    reset    = 1'b0;
    tick();
    check("ready_after_reset", 64'(op_ready), 64'd1);

    // Preload HI/LO.
    run_op("mthi", OP_MTHI, 32'h11, 32'h0, 1);
    run_op("mtlo", OP_MTLO, 32'h22, 32'h0, 1);

    // DIVU 10/3 cancelled by flush in cycle 5 of the operation.
    drive(OP_DIVU, 32'd10, 32'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      op_valid = 1'b0;
    end
    flush = 1'b1;
    check("flush_busy_before", 64'(busy), 64'd1);
    tick();
    flush = 1'b0;
    check("flush_ready_after", 64'(op_ready), 64'd1);
    check("flush_busy_after", 64'(busy), 64'd0);
    check("flush_state_idle", 64'(dbg_state), 64'(ST_IDLE));
    check("flush_hilo_kept", {hi, lo}, {32'h11, 32'h22});
    repeat (40) tick();  // no res_valid may appear (monitor)

    // Flush coincident with a request in IDLE: not accepted.
    drive(OP_MTHI, 32'h99, 32'h0);
    flush = 1'b1;
    tick();
    op_valid = 1'b0;
    flush    = 1'b0;
    check("flush_idle_res_valid", 64'(res_valid), 64'd0);
    check("flush_idle_hi", 64'(hi), 64'h11);

    // Directed vectors.
    run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, DIV_LAT);
    run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, DIV_LAT);
    run_op("div_by0", OP_DIV, 32'hFFFF_FF00, 32'd0, DIV_LAT);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, DIV_LAT);
    run_op("mult_m1x2", OP_MULT, 32'hFFFF_FFFF, 32'd2, MUL_LAT);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
    run_op("mult_neg_pos", OP_MULT, 32'h8000_0000, 32'd3, MUL_LAT);
    run_op("div_pos_neg", OP_DIV, 32'd17, 32'hFFFF_FFFB, DIV_LAT);
    run_op("nop", OP_NOP, 32'h5555_5555, 32'h0, 1);

    // MTLO then immediately DIVU 9/4, with a second request held during RUN.
    run_op("mtlo_1234", OP_MTLO, 32'h1234, 32'h0, 1);
    drive(OP_DIVU, 32'd9, 32'd4);
    push_op(OP_DIVU, 32'd9, 32'd4);
    tick();
    drive(OP_MTHI, 32'hAA, 32'h0);
    push_op(OP_MTHI, 32'hAA, 32'h0);
    lat = 1;
    while (!res_valid && lat < 100) begin
      if (lat == 10) check("held_req_not_ready", 64'(op_ready), 64'd0);
      tick();
      lat++;
    end
    check("divu_9_4_latency", 64'(lat), 64'(DIV_LAT));
    tick();
    check("held_req_ready_idle", 64'(op_ready), 64'd1);
    tick();
    op_valid = 1'b0;
    check("held_req_res_valid", 64'(res_valid), 64'd1);

    // Flush in the res_valid (DONE) cycle leaves the written result.
    for (int i = 0; i < 50 && !op_ready; i++) tick();
    drive(OP_DIVU, 32'h1F, 32'd5);
    push_op(OP_DIVU, 32'h1F, 32'd5);
    tick();
    op_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("done_flush_latency", 64'(lat), 64'(DIV_LAT));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("done_flush_hilo", {hi, lo}, {32'd1, 32'd6});
    check("done_flush_ready", 64'(op_ready), 64'd1);

    // Random mix.
    for (int i = 0; i < 8; i++) begin
      rc = 3'($urandom_range(0, 6));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 9)) : $urandom;
      run_op("random", rc, ra, rb, lat_of(rc));
    end

    // Reset in the middle of a divide.
    for (int i = 0; i < 50 && !op_ready; i++) tick();
    drive(OP_DIV, 32'd1000, 32'd7);
    tick();
    op_valid = 1'b0;
    repeat (9) tick();
    check("mid_div_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    tick();
    check("mid_reset_hi", 64'(hi), 64'd0);
    check("mid_reset_lo", 64'(lo), 64'd0);
    check("mid_reset_busy", 64'(busy), 64'd0);
    check("mid_reset_ready", 64'(op_ready), 64'd0);
    reset  = 1'b0;
    cur_hi = '0;
    cur_lo = '0;
    tick();
    check("post_reset_ready", 64'(op_ready), 64'd1);
    repeat (40) tick();  // the cancelled divide must not report
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
